// File: rtl/dino_gfx_pkg.sv
// rtl/dino_gfx_pkg.sv - shared framebuffer/sprite constants, blitter state type, coordinate reduce helper
// Contents: framebuffer geometry defaults, bus widths, transparent colour key,
//           blitter FSM state enum, reduce_coord() used to fold positions at request acceptance.
package dino_gfx_pkg;

  localparam int FB_WIDTH   = 320;
  localparam int FB_HEIGHT  = 240;
  localparam int FB_ADDR_W  = 17;
  localparam int COLOR_W    = 12;
  localparam int ROM_ADDR_W = 14;
  localparam int POS_W      = 9;
  localparam int SIZE_W     = 7;

  localparam logic [COLOR_W-1:0] TRANSPARENT_KEY = 12'hF0F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } blit_state_e;

  // Folds a 9-bit coordinate into [0, limit) by repeated conditional subtraction.
  // Four steps are enough for any limit >= 128, since 511 < 4 * 128.
  function automatic logic [POS_W-1:0] reduce_coord(input logic [POS_W-1:0] v,
                                                    input logic [POS_W-1:0] limit);
    logic [POS_W-1:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (r >= limit) r = r - limit;
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_blit_writer_if.sv
// rtl/sprite_blit_writer_if.sv - draw request, sprite ROM and framebuffer write signal bundle
// Signals: start, pos_x, pos_y, spr_w, spr_h, spr_base (draw request)
//          rom_addr / rom_data (sprite ROM, data one cycle after address)
//          fb_we, fb_addr, fb_data (framebuffer write port), busy, done (status)
// Modports: slave  - the blitter (request and rom_data in; rom_addr, fb_*, busy, done out)
//           master - requester / memory side, directions mirrored
interface sprite_blit_writer_if;
  import dino_gfx_pkg::*;

  logic                  start;
  logic [POS_W-1:0]      pos_x;
  logic [POS_W-1:0]      pos_y;
  logic [SIZE_W-1:0]     spr_w;
  logic [SIZE_W-1:0]     spr_h;
  logic [ROM_ADDR_W-1:0] spr_base;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [COLOR_W-1:0]    rom_data;
  logic                  fb_we;
  logic [FB_ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0]    fb_data;
  logic                  busy;
  logic                  done;

  modport master (
    output start, pos_x, pos_y, spr_w, spr_h, spr_base, rom_data,
    input  rom_addr, fb_we, fb_addr, fb_data, busy, done
  );

  modport slave (
    input  start, pos_x, pos_y, spr_w, spr_h, spr_base, rom_data,
    output rom_addr, fb_we, fb_addr, fb_data, busy, done
  );

endinterface

// File: rtl/sprite_blit_writer_wrap_counter.sv
// rtl/sprite_blit_writer_wrap_counter.sv - loadable up-counter that wraps to 0 after LIMIT-1
// Ports: clk, rst_n (async active-low), load_i/load_val_i (load has priority),
//        inc_i (advance by one, wrapping at LIMIT), count_o (current value)
module wrap_counter #(
  parameter int W     = 9,
  parameter int LIMIT = 320
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/sprite_blit_writer.sv
// rtl/sprite_blit_writer.sv - copies a sprite from ROM into the framebuffer with edge wrap
// Ports: clk, rst (async active-low), bus (sprite_blit_writer_if.slave: draw request,
//        sprite ROM port, framebuffer write port, busy/done status)
// Option: BLIT_TRANSPARENCY_EN - suppress writes of pixels equal to TRANSPARENT_KEY
module sprite_blit_writer
  import dino_gfx_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input  logic                 clk,
  input  logic                 rst,
  sprite_blit_writer_if.slave  bus
);

  blit_state_e state_q, state_d;

  logic [SIZE_W-1:0]     w_q, h_q;
  logic [SIZE_W-1:0]     col_q, row_q;
  logic [POS_W-1:0]      x0_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic                  fb_we_q;
  logic [FB_ADDR_W-1:0]  fb_addr_q;

  logic                  accept;
  logic                  step;
  logic                  zero_size;
  logic                  row_end;
  logic                  last_pix;
  logic [POS_W-1:0]      pos_x_red, pos_y_red;
  logic [POS_W-1:0]      dx, dy;
  logic [FB_ADDR_W-1:0]  fb_addr_cur;

  assign zero_size = (bus.spr_w == '0) || (bus.spr_h == '0);
  assign pos_x_red = reduce_coord(bus.pos_x, POS_W'(WIDTH));
  assign pos_y_red = reduce_coord(bus.pos_y, POS_W'(HEIGHT));
  assign row_end   = (col_q == w_q - SIZE_W'(1));
  assign last_pix  = row_end && (row_q == h_q - SIZE_W'(1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = zero_size ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_pix) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // dx restarts at the latched left edge at every row end; dy only steps at row ends.
  wrap_counter #(.W(POS_W), .LIMIT(WIDTH)) u_dx (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (accept || (step && row_end)),
    .load_val_i (accept ? pos_x_red : x0_q),
    .inc_i      (step && !row_end),
    .count_o    (dx)
  );

  wrap_counter #(.W(POS_W), .LIMIT(HEIGHT)) u_dy (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (accept),
    .load_val_i (pos_y_red),
    .inc_i      (step && row_end),
    .count_o    (dy)
  );

  assign fb_addr_cur = FB_ADDR_W'(dx) + FB_ADDR_W'(WIDTH) * FB_ADDR_W'(dy);

  // Row-major order makes the ROM address a plain running increment from spr_base.
  // The fb address for a pixel is registered alongside its ROM address so both
  // arrive together with the ROM data one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      w_q        <= '0;
      h_q        <= '0;
      col_q      <= '0;
      row_q      <= '0;
      x0_q       <= '0;
      rom_addr_q <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      fb_we_q <= step;
      if (step) fb_addr_q <= fb_addr_cur;
      if (accept) begin
        w_q        <= bus.spr_w;
        h_q        <= bus.spr_h;
        x0_q       <= pos_x_red;
        rom_addr_q <= bus.spr_base;
        col_q      <= '0;
        row_q      <= '0;
      end else if (step) begin
        rom_addr_q <= rom_addr_q + ROM_ADDR_W'(1);
        if (row_end) begin
          col_q <= '0;
          row_q <= row_q + SIZE_W'(1);
        end else begin
          col_q <= col_q + SIZE_W'(1);
        end
      end
    end
  end

  assign bus.rom_addr = rom_addr_q;
  assign bus.fb_addr  = fb_addr_q;
  // Gating keeps fb_data at zero while reset holds fb_we_q low.
  assign bus.fb_data  = fb_we_q ? bus.rom_data : '0;
`ifdef BLIT_TRANSPARENCY_EN
  assign bus.fb_we    = fb_we_q && (bus.rom_data != TRANSPARENT_KEY);
`else
  assign bus.fb_we    = fb_we_q;
`endif
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = (state_q == ST_FIN);

endmodule

// File: tb/tb_sprite_blit_writer.sv
// tb/tb_sprite_blit_writer.sv - self-checking bench for sprite_blit_writer with ROM and reference model
module tb_sprite_blit_writer;

  localparam int TW = 320;
  localparam int TH = 240;
  localparam logic [11:0] KEY = 12'hF0F;
`ifdef BLIT_TRANSPARENCY_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_blit_writer_if bus ();

  sprite_blit_writer #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [11:0] rom_mem [16384];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: at acceptance, the full list of pixel writes is computed
  // from the geometry rules; timing follows from the pixel count alone.
  bit          m_active;
  int          m_t, m_n, m_l;
  int          exp_addr[$];
  int          exp_rom[$];
  logic [11:0] exp_data[$];
  int          b_px, b_py, b_w, b_h, b_b, b_sx, b_sy, b_ra;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_t = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == m_l) m_active = 1'b0;
    end else if (bus.start) begin
      b_px = int'(bus.pos_x); b_py = int'(bus.pos_y);
      b_w = int'(bus.spr_w);  b_h = int'(bus.spr_h); b_b = int'(bus.spr_base);
      b_sx = b_px % TW; b_sy = b_py % TH;
      exp_addr.delete(); exp_rom.delete(); exp_data.delete();
      for (int r = 0; r < b_h; r++) begin
        for (int c = 0; c < b_w; c++) begin
          b_ra = (b_b + r * b_w + c) % 16384;
          exp_rom.push_back(b_ra);
          exp_data.push_back(rom_mem[b_ra]);
          exp_addr.push_back(((b_sx + c) % TW) + TW * ((b_sy + r) % TH));
        end
      end
      m_n = b_w * b_h;
      m_l = (m_n == 0) ? 1 : m_n + 2;
      m_t = 0;
      m_active = 1'b1;
    end
  end

  int cap[$];
  int busy_n, done_n, done_c;
  int cyc, kk;
  bit e_busy, e_done, e_we;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_fb_we", bus.fb_we, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_fb_addr", bus.fb_addr, 0);
      chk("rst_fb_data", bus.fb_data, 0);
    end else begin
      cyc = m_t + 1;
      e_busy = m_active;
      e_done = m_active && (cyc == m_l);
      e_we = 1'b0;
      kk = cyc - 2;
      if (m_active && m_n > 0 && cyc >= 2 && cyc <= m_n + 1)
        e_we = !(TRANSP && exp_data[kk] == KEY);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("fb_we", bus.fb_we, e_we);
      if (e_we && bus.fb_we) begin
        chk("fb_addr", bus.fb_addr, exp_addr[kk]);
        chk("fb_data", bus.fb_data, exp_data[kk]);
      end
      if (m_active && cyc <= m_n) chk("rom_addr", bus.rom_addr, exp_rom[cyc-1]);
      if (bus.fb_we) cap.push_back(int'(bus.fb_addr));
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_c = m_active ? cyc : -1;
      end
    end
  end

  task automatic clear_capture();
    cap.delete();
    busy_n = 0;
    done_n = 0;
    done_c = -1;
  endtask

  task automatic set_req(input int px, input int py, input int w, input int h, input int b);
    bus.pos_x = 9'(px);
    bus.pos_y = 9'(py);
    bus.spr_w = 7'(w);
    bus.spr_h = 7'(h);
    bus.spr_base = 14'(b);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (m_active && i < 20000) begin
      @(negedge clk);
      i++;
    end
    chk("draw_timeout", m_active, 0);
  endtask

  task automatic draw(input int px, input int py, input int w, input int h, input int b);
    clear_capture();
    set_req(px, py, w, h, b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
  endtask

  int lit28[8] = '{6410, 6411, 6412, 6413, 6730, 6731, 6732, 6733};
  int lit29[6] = '{76798, 76799, 76480, 318, 319, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    set_req(0, 0, 0, 0, 0);
    for (int i = 0; i < 16384; i++) rom_mem[i] = 12'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    draw(10, 20, 4, 2, 0);
    chk("r28_nwr", cap.size(), 8);
    for (int i = 0; i < 8; i++) if (i < cap.size()) chk("r28_addr", cap[i], lit28[i]);
    chk("r28_done_cyc", done_c, 10);

    draw(318, 239, 3, 2, 100);
    chk("r29_nwr", cap.size(), 6);
    for (int i = 0; i < 6; i++) if (i < cap.size()) chk("r29_addr", cap[i], lit29[i]);
    chk("r29_done_cyc", done_c, 8);

    draw(5, 5, 0, 3, 7);
    chk("r30_nwr", cap.size(), 0);
    chk("r30_done_cyc", done_c, 1);
    chk("r30_busy_cyc", busy_n, 1);
    draw(5, 5, 3, 0, 7);
    chk("r30h_nwr", cap.size(), 0);
    chk("r30h_done_cyc", done_c, 1);

    clear_capture();
    set_req(3, 4, 3, 2, 50);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    set_req(100, 100, 5, 5, 900);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    chk("r31_nwr", cap.size(), 6);
    chk("r31_done_n", done_n, 1);

    clear_capture();
    set_req(40, 50, 4, 4, 2000);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && cap.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("r32_nwr", cap.size(), 3);
    chk("r32_done_n", done_n, 0);
    draw(7, 9, 2, 2, 300);
    chk("r32_after_nwr", cap.size(), 4);
    chk("r32_after_done_cyc", done_c, 6);

    rom_mem[201] = KEY;
    draw(0, 0, 4, 1, 200);
    chk("r33_nwr", cap.size(), TRANSP ? 3 : 4);
    if (cap.size() > 1) chk("r33_addr1", cap[1], TRANSP ? 2 : 1);
    chk("r33_done_cyc", done_c, 6);

    draw(300, 500, 5, 3, 16380);
    chk("romwrap_nwr", cap.size(), 15);

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      draw($urandom_range(0, 511), $urandom_range(0, 511), $urandom_range(0, 9),
           $urandom_range(0, 9), $urandom_range(0, 16383));
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_blit_writer.md
SPRITE_BLIT_WRITER -- requirements
Module: sprite_blit_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 320, meaning framebuffer width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 240, meaning framebuffer height in pixels.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, draw request; accepted only in IDLE.
REQ-006 SHALL have ports pos_x and pos_y, input, 9 each, destination top-left pixel; sampled at acceptance.
REQ-007 SHALL have ports spr_w and spr_h, input, 7 each, sprite size in pixels (0..127); sampled at acceptance.
REQ-008 SHALL have port spr_base, input, 14, first sprite ROM word; sampled at acceptance.
REQ-009 SHALL have ports rom_addr, output, 14, and rom_data, input, 12; rom_data is valid exactly one cycle after rom_addr.
REQ-010 SHALL have ports fb_we, output, 1; fb_addr, output, 17; fb_data, output, 12 (framebuffer write port, 4-4-4 RGB).
REQ-011 SHALL have ports busy, output, 1, and done, output, 1 (one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, FIN.
- IDLE->RUN: start=1 with spr_w!=0 and spr_h!=0.
- IDLE->FIN: start=1 with spr_w=0 or spr_h=0; no writes.
- RUN->DRAIN: cycle the last ROM address is issued.
- DRAIN->FIN: after the last write cycle.
- FIN->IDLE: unconditionally, with done=1 during FIN.
REQ-013 SHALL assert busy in RUN, DRAIN and FIN; deassert in IDLE.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL issue one ROM address per RUN cycle, row-major: spr_base + row*spr_w + col, mod 2^14.
REQ-016 SHALL present the fb write for each pixel exactly one cycle after its ROM address, with fb_data=rom_data.
REQ-017 SHALL compute dx=(pos_x+col) mod WIDTH and dy=(pos_y+row) mod HEIGHT; fb_addr = dx + WIDTH*dy, wrapping at the right and bottom edges.
REQ-018 SHALL reduce pos_x>=WIDTH and pos_y>=HEIGHT modulo WIDTH/HEIGHT at acceptance.
REQ-019 SHALL produce dx/dy with incrementing wrap counters, without a divider or modulo operator.
REQ-020 SHALL perform exactly spr_w*spr_h write cycles per request; done rises spr_w*spr_h+2 cycles after the accepting edge.
REQ-021 SHALL hold fb_we=0 outside write cycles; fb_addr/fb_data are don't-care when fb_we=0.

Reset
REQ-022 SHALL, on rst=0, immediately force state IDLE, busy=0, done=0, fb_we=0, rom_addr=0, fb_addr=0, fb_data=0, and zero all counters.
REQ-023 SHALL abort any draw in progress on reset, with no further writes and no done pulse.

Configuration
REQ-024 SHALL, with BLIT_TRANSPARENCY_EN defined, hold fb_we=0 for a pixel whose rom_data equals the package transparent key 12'hF0F; timing and done latency are unchanged.
REQ-025 SHALL, without BLIT_TRANSPARENCY_EN, write every pixel regardless of colour.

Structure
REQ-026 SHALL take WIDTH/HEIGHT defaults, FB_ADDR_W=17, COLOR_W=12, ROM_ADDR_W=14 and TRANSPARENT_KEY from shared package dino_gfx_pkg.
REQ-027 SHALL instantiate sub-module wrap_counter (count, load, wrap at limit) twice, for dx and dy.

Verification
REQ-028 SHALL cover: pos=(10,20), size 4x2, base 0 -> 8 writes at fb_addr 6410..6413 and 6730..6733, done 10 cycles after the accepting edge.
REQ-029 SHALL cover: pos=(318,239), size 3x2 -> writes to x 318,319,0 on row 239, then row 0 (addresses 76798,76799,76480,318,319,0).
REQ-030 SHALL cover: spr_w=0 -> no fb_we, done pulse one cycle after acceptance, busy high for 1 cycle.
REQ-031 SHALL cover: start pulsed again mid-draw -> ignored; write count stays spr_w*spr_h.
REQ-032 SHALL cover: rst=0 after the 3rd write of a 4x4 draw -> fb_we=0 immediately, no done; a subsequent start draws normally.
REQ-033 SHALL cover: BLIT_TRANSPARENCY_EN defined, ROM word 12'hF0F at column 1 -> no write at that pixel, all others written, done timing unchanged.
